// File: rtl/uart_baud_gen_frac.sv
// Fractional baud / oversample tick generator with shadowed reconfiguration,
// bit-boundary and mid-bit pulses, and an RX phase-resync input.
module uart_baud_gen_frac #(
   parameter int CNT_W  = 16,
   parameter int FRAC_W = 4,
   parameter int OSR_W  = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              cfg_load,
   input  logic [CNT_W-1:0]  baud_div,
   input  logic [FRAC_W-1:0] baud_frac,
   input  logic [OSR_W-1:0]  osr,
   input  logic              resync,
   output logic              cfg_busy,
   output logic              baud_tick,
   output logic              xmit_pulse,
   output logic              sample_pulse
);

   logic [CNT_W-1:0]  cnt;
   logic [FRAC_W-1:0] acc;
   logic              stretch;
   logic [OSR_W-1:0]  os_cnt;

   logic [CNT_W-1:0]  div_act,  div_stg;
   logic [FRAC_W-1:0] frac_act, frac_stg;
   logic [OSR_W-1:0]  osr_act,  osr_stg;

   logic              tick_now;
   logic              xmit_now;
   logic              sample_now;
   logic              apply;
   logic [FRAC_W:0]   acc_sum;

   // Apply only at a bit boundary (or while stopped) so no bit is ever
   // timed by a mix of old and new settings.
   always_comb begin
      tick_now   = enable & ~resync & (cnt == '0) & ~stretch;
      xmit_now   = tick_now & (os_cnt == osr_act);
      sample_now = tick_now & (os_cnt == (osr_act >> 1));
      apply      = cfg_busy & (~enable | xmit_now);
      acc_sum    = {1'b0, acc} + {1'b0, frac_act};
   end

   // NOTE: every register here is a plain flop, so all are cleared by the
   // asynchronous reset; state updates use non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt          <= '0;
         acc          <= '0;
         stretch      <= 1'b0;
         os_cnt       <= '0;
         baud_tick    <= 1'b0;
         xmit_pulse   <= 1'b0;
         sample_pulse <= 1'b0;
      end else begin
         baud_tick    <= tick_now;
         xmit_pulse   <= xmit_now;
         sample_pulse <= sample_now;
         if (resync) begin
            cnt     <= div_act;
            acc     <= '0;
            stretch <= 1'b0;
            os_cnt  <= '0;
         end else if (enable) begin
            if (cnt != '0) begin
               cnt <= cnt - CNT_W'(1);
            end else if (stretch) begin
               stretch <= 1'b0;
            end else if (apply) begin
               // New bit period starts from the staged divisor with a clean phase.
               cnt     <= div_stg;
               acc     <= '0;
               stretch <= 1'b0;
               os_cnt  <= '0;
            end else begin
               cnt     <= div_act;
               acc     <= acc_sum[FRAC_W-1:0];
               stretch <= acc_sum[FRAC_W];
               os_cnt  <= xmit_now ? '0 : os_cnt + OSR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_act  <= '0;
         frac_act <= '0;
         osr_act  <= '0;
         div_stg  <= '0;
         frac_stg <= '0;
         osr_stg  <= '0;
         cfg_busy <= 1'b0;
      end else begin
         if (apply) begin
            div_act  <= div_stg;
            frac_act <= frac_stg;
            osr_act  <= osr_stg;
         end
         // A fresh capture on the apply edge stays pending for the next boundary.
         if (cfg_load) begin
            div_stg  <= baud_div;
            frac_stg <= baud_frac;
            osr_stg  <= osr;
            cfg_busy <= 1'b1;
         end else if (apply) begin
            cfg_busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Scoreboard bench for uart_baud_gen_frac: expected tick cycles and pulse
// flags are queued per scenario and compared as the DUT emits ticks.
module tb_uart_baud_gen_frac;

   localparam int CNT_W  = 16;
   localparam int FRAC_W = 4;
   localparam int OSR_W  = 5;

   typedef struct {
      int t;
      bit x;
      bit s;
   } ev_t;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              enable = 1'b0;
   logic              cfg_load = 1'b0;
   logic [CNT_W-1:0]  baud_div = '0;
   logic [FRAC_W-1:0] baud_frac = '0;
   logic [OSR_W-1:0]  osr = '0;
   logic              resync = 1'b0;
   logic              cfg_busy;
   logic              baud_tick;
   logic              xmit_pulse;
   logic              sample_pulse;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   bit   mon_on = 1'b0;
   ev_t  exp_q[$];
   int   obs_q[$];

   uart_baud_gen_frac #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .OSR_W(OSR_W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .cfg_load     (cfg_load),
      .baud_div     (baud_div),
      .baud_frac    (baud_frac),
      .osr          (osr),
      .resync       (resync),
      .cfg_busy     (cfg_busy),
      .baud_tick    (baud_tick),
      .xmit_pulse   (xmit_pulse),
      .sample_pulse (sample_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Expected tick schedule: interval div+1, plus one after each fractional carry.
   function automatic void push_ticks(input int first, input int lim, input int div,
                                      input int frac, input int ratio, input int os0);
      int  t   = first;
      int  acc = 0;
      int  os  = os0;
      int  c;
      ev_t e;
      while (t < lim) begin
         e.t = t;
         e.x = (os == ratio);
         e.s = (os == (ratio >> 1));
         exp_q.push_back(e);
         acc = acc + frac;
         c   = (acc >= (1 << FRAC_W)) ? 1 : 0;
         acc = acc % (1 << FRAC_W);
         os  = (os == ratio) ? 0 : os + 1;
         t   = t + div + 1 + c;
      end
   endfunction

   always @(negedge clk) begin
      if (mon_on && (baud_tick || xmit_pulse || sample_pulse)) begin
         ev_t e;
         obs_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {baud_tick, xmit_pulse, sample_pulse}, 0);
         end else begin
            e = exp_q.pop_front();
            check("tick_cycle", cyc, e.t);
            check("tick_flags", {baud_tick, xmit_pulse, sample_pulse}, {1'b1, e.x, e.s});
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      mon_on    = 1'b0;
      enable    = 1'b0;
      cfg_load  = 1'b0;
      resync    = 1'b0;
      baud_div  = '0;
      baud_frac = '0;
      osr       = '0;
      reset_n   = 1'b0;
      cycles(2);
      reset_n = 1'b1;
      cycles(1);
   endtask

   task automatic start_cfg(input int div, input int frac, input int ratio);
      do_reset();
      baud_div  = CNT_W'(div);
      baud_frac = FRAC_W'(frac);
      osr       = OSR_W'(ratio);
      cfg_load  = 1'b1;
      cycles(1);
      cfg_load = 1'b0;
      check("busy_after_load", cfg_busy, 1);
      cycles(1);
      check("busy_clear_disabled", cfg_busy, 0);
   endtask

   task automatic open_window();
      exp_q.delete();
      obs_q.delete();
      mon_on = 1'b1;
   endtask

   task automatic close_window(input string tag);
      mon_on = 1'b0;
      check(tag, exp_q.size(), 0);
   endtask

   initial begin
      int e0;
      int r0;
      int n6;

      // Reset state
      #2;
      check("reset_tick", baud_tick, 0);
      check("reset_xmit", xmit_pulse, 0);
      check("reset_sample", sample_pulse, 0);
      check("reset_busy", cfg_busy, 0);

      // 1: integer 16x
      start_cfg(4, 0, 15);
      open_window();
      enable = 1'b1;
      e0 = cyc;
      push_ticks(e0 + 1, e0 + 200, 4, 0, 15, 0);
      cycles(200);
      close_window("t1_drained");

      // 2: fractional 1/2, then 15/16
      start_cfg(4, 8, 15);
      open_window();
      enable = 1'b1;
      e0 = cyc;
      push_ticks(e0 + 1, e0 + 120, 4, 8, 15, 0);
      cycles(120);
      close_window("t2a_drained");
      check("t2a_enough_ticks", obs_q.size() >= 17, 1);
      if (obs_q.size() >= 17) begin
         check("t2a_first_interval", obs_q[1] - obs_q[0], 5);
         check("t2a_second_interval", obs_q[2] - obs_q[1], 6);
         check("t2a_16_ticks_span", obs_q[16] - obs_q[0], 88);
      end

      start_cfg(4, 15, 15);
      open_window();
      enable = 1'b1;
      e0 = cyc;
      push_ticks(e0 + 1, e0 + 120, 4, 15, 15, 0);
      cycles(120);
      close_window("t2b_drained");
      check("t2b_enough_ticks", obs_q.size() >= 17, 1);
      if (obs_q.size() >= 17) begin
         n6 = 0;
         for (int i = 1; i <= 16; i++) if (obs_q[i] - obs_q[i-1] == 6) n6++;
         check("t2b_six_cycle_intervals", n6, 15);
      end

      // 3: degenerate settings
      start_cfg(0, 0, 0);
      open_window();
      enable = 1'b1;
      e0 = cyc;
      push_ticks(e0 + 1, e0 + 40, 0, 0, 0, 0);
      cycles(40);
      close_window("t3a_drained");

      start_cfg(0, 0, 7);
      open_window();
      enable = 1'b1;
      e0 = cyc;
      push_ticks(e0 + 1, e0 + 40, 0, 0, 7, 0);
      cycles(40);
      close_window("t3b_drained");

      // 4: reconfiguration lands on the bit boundary
      start_cfg(4, 0, 15);
      open_window();
      enable = 1'b1;
      e0 = cyc;
      push_ticks(e0 + 1, e0 + 77, 4, 0, 15, 0);
      push_ticks(e0 + 86, e0 + 200, 9, 0, 15, 0);
      cycles(25);
      baud_div = CNT_W'(9);
      cfg_load = 1'b1;
      cycles(1);
      cfg_load = 1'b0;
      check("t4_busy_after_load", cfg_busy, 1);
      cycles(49);
      check("t4_busy_before_boundary", cfg_busy, 1);
      cycles(1);
      check("t4_busy_after_boundary", cfg_busy, 0);
      cycles(124);
      close_window("t4_drained");

      // 5: resync mid-bit, then resync while disabled
      start_cfg(4, 0, 15);
      open_window();
      enable = 1'b1;
      e0 = cyc;
      push_ticks(e0 + 1, e0 + 53, 4, 0, 15, 0);
      push_ticks(e0 + 58, e0 + 151, 4, 0, 15, 0);
      push_ticks(e0 + 162, e0 + 220, 4, 0, 15, 0);
      cycles(52);
      resync = 1'b1;
      cycles(1);
      resync = 1'b0;
      cycles(97);
      enable = 1'b0;
      cycles(3);
      resync = 1'b1;
      cycles(1);
      resync = 1'b0;
      cycles(3);
      enable = 1'b1;
      r0 = cyc;
      check("t5_reenable_cycle", r0 - e0, 157);
      cycles(63);
      close_window("t5_drained");

      // 6a: enable dropped for 7 cycles mid-interval
      start_cfg(4, 0, 15);
      open_window();
      enable = 1'b1;
      e0 = cyc;
      push_ticks(e0 + 1, e0 + 13, 4, 0, 15, 0);
      push_ticks(e0 + 23, e0 + 80, 4, 0, 15, 3);
      cycles(12);
      enable = 1'b0;
      cycles(7);
      enable = 1'b1;
      cycles(61);
      close_window("t6a_drained");

      // 6b: asynchronous reset with a config pending
      start_cfg(4, 0, 15);
      enable = 1'b1;
      cycles(20);
      baud_div = CNT_W'(9);
      cfg_load = 1'b1;
      cycles(1);
      cfg_load = 1'b0;
      check("t6b_busy_pending", cfg_busy, 1);
      cycles(5);
      check("t6b_tick_before_reset", baud_tick, 1);
      reset_n = 1'b0;
      #1;
      check("t6b_tick_in_reset", baud_tick, 0);
      check("t6b_xmit_in_reset", xmit_pulse, 0);
      check("t6b_sample_in_reset", sample_pulse, 0);
      check("t6b_busy_in_reset", cfg_busy, 0);
      cycles(2);
      open_window();
      reset_n = 1'b1;
      e0 = cyc;
      push_ticks(e0 + 1, e0 + 20, 0, 0, 0, 0);
      cycles(20);
      close_window("t6b_zero_config_drained");
      check("t6b_busy_after_reset", cfg_busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
